// File: rtl/pcie_inorder_tx_pkg.sv
// Shared types and helpers for the card-to-host in-order write engine.
package pcie_tx_pkg;
   typedef enum logic [1:0] {IDLE, DATA, TAIL} state_t;
   typedef logic [63:0] cnt64_t;

   function automatic int unsigned beat_bytes(input int unsigned w);
      return w / 8;
   endfunction
endpackage

// File: rtl/pcie_inorder_tx_if.sv
// Input word stream plus the PCIe half-beat write bus.
interface pcie_inorder_tx_if #(parameter int W = 512);
   localparam int W2 = W / 2;

   logic                 in_v;
   logic [W-1:0]         in_d;
   logic                 in_r;
   logic [1:0]           pcie_v;
   logic [63:0]          pcie_a;
   logic [1:0][W2-1:0]   pcie_d;
   logic                 pcie_r;

   modport master (output in_v, in_d, pcie_r, input in_r, pcie_v, pcie_a, pcie_d);
   modport slave  (input in_v, in_d, pcie_r, output in_r, pcie_v, pcie_a, pcie_d);
endinterface

// File: rtl/pcie_inorder_tx_fifo.sv
// First-word-fall-through FIFO; the read pointer advances on load (i_pop) while
// the occupancy count only drops when the loaded word is accepted (i_rel).
module pcie_tx_fifo #(
   parameter int W   = 512,
   parameter int D   = 512,
   parameter int D_L = $clog2(D)
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_v,
   input  logic [W-1:0] i_d,
   output logic         o_r,
   input  logic         i_pop,
   input  logic         i_rel,
   output logic [W-1:0] o_head,
   output logic [D_L:0] o_cnt
);
   localparam logic [D_L:0] D_C = (D_L+1)'(D);

   logic [D_L-1:0] r_wp, r_rp, w_rp_nxt;
   logic [D_L:0]   r_cnt, w_cnt_nxt;
   logic           w_push, r_byp;
   logic [W-1:0]   r_byp_d, w_q;

   assign w_push    = i_v & o_r;
   assign w_rp_nxt  = r_rp + D_L'(i_pop);
   assign w_cnt_nxt = r_cnt + (D_L+1)'(w_push) - (D_L+1)'(i_rel);

   // Reading at the next pointer keeps the head word ready with no extra latency.
   simple_dual_port_ram #(.DW(W), .AW(D_L)) u_ram (
      .i_clk   (i_clk),
      .i_we    (w_push),
      .i_waddr (r_wp),
      .i_wdata (i_d),
      .i_raddr (w_rp_nxt),
      .o_rdata (w_q)
   );

   always_ff @(posedge i_clk) begin
      r_byp_d <= i_d;
      if (i_rst) begin
         r_wp  <= '0;
         r_rp  <= '0;
         r_cnt <= '0;
         o_r   <= 1'b0;
         r_byp <= 1'b0;
      end else begin
         r_wp  <= r_wp + D_L'(w_push);
         r_rp  <= w_rp_nxt;
         r_cnt <= w_cnt_nxt;
         o_r   <= (w_cnt_nxt < D_C);
         // A write landing on the head slot is invisible to a read-first RAM.
         r_byp <= w_push && (r_wp == w_rp_nxt);
      end
   end

   assign o_head = r_byp ? r_byp_d : w_q;
   assign o_cnt  = r_cnt;
endmodule

// File: rtl/simple_dual_port_ram.sv
// One write port, one registered read port, common clock, read-first on collision.
module simple_dual_port_ram #(
   parameter int DW = 512,
   parameter int AW = 9
) (
   input  logic          i_clk,
   input  logic          i_we,
   input  logic [AW-1:0] i_waddr,
   input  logic [DW-1:0] i_wdata,
   input  logic [AW-1:0] i_raddr,
   output logic [DW-1:0] o_rdata
);
   logic [DW-1:0] r_mem [2**AW];

   always_ff @(posedge i_clk) begin
      if (i_we) r_mem[i_waddr] <= i_wdata;
      o_rdata <= r_mem[i_raddr];
   end
endmodule

// File: rtl/pcie_inorder_tx.sv
// Drains buffered words as PCIe ring writes in bursts, then posts the beat count
// to a tail doorbell; host_head provides ring credit.
module pcie_inorder_tx
   import pcie_tx_pkg::*;
#(
   parameter logic [63:0] ADDR_VAL  = 64'h0000_0000_0000_0000,
   parameter logic [63:0] TAIL_ADDR = 64'h0000_0000_0001_0000,
   parameter int W     = 512,
   parameter int D     = 512,
   parameter int BURST = 8,
   parameter int RING  = 4096,
   parameter int W2    = W / 2,
   parameter int D_L   = $clog2(D)
) (
   input  logic   clk,
   input  logic   rst,
   input  logic   flush,
   input  cnt64_t host_head,
   output cnt64_t sent,
   output logic   busy,
   pcie_inorder_tx_if.slave bus
);
   localparam int RL = $clog2(RING);
   localparam int LW = $clog2(BURST + 1);
   localparam logic [63:0]  BB      = 64'(beat_bytes(W));
   localparam logic [D_L:0] BURST_C = (D_L+1)'(BURST);

   state_t             r_state, w_nstate;
   logic [1:0]         r_pv;
   logic [63:0]        r_pa;
   logic [1:0][W2-1:0] r_pd;
   cnt64_t             r_sent, w_free;
   logic [RL-1:0]      r_idx, w_idx_ld;
   logic [LW-1:0]      r_left, w_len;
   logic               r_fp;
   logic [W-1:0]       w_head;
   logic [D_L:0]       w_cnt;
   logic               w_acc, w_rel, w_launch, w_ld_beat, w_ld_tail, w_to_idle;

   pcie_tx_fifo #(.W(W), .D(D), .D_L(D_L)) u_fifo (
      .i_clk  (clk),
      .i_rst  (rst),
      .i_v    (bus.in_v),
      .i_d    (bus.in_d),
      .o_r    (bus.in_r),
      .i_pop  (w_ld_beat),
      .i_rel  (w_rel),
      .o_head (w_head),
      .o_cnt  (w_cnt)
   );

   assign w_acc    = (|r_pv) & bus.pcie_r;
   assign w_rel    = w_acc && (r_state == DATA);
   assign w_len    = (w_cnt >= BURST_C) ? LW'(BURST) : LW'(w_cnt);
   assign w_free   = cnt64_t'(RING) - (r_sent - host_head);
   assign w_launch = (r_state == IDLE) && ((w_cnt >= BURST_C) || (r_fp && (w_cnt != '0)))
                     && (w_free >= 64'(w_len));
   assign w_idx_ld = (r_state == DATA) ? r_idx + RL'(1) : r_idx;

   always_ff @(posedge clk) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_nstate;
   end

   always_comb begin
      w_nstate  = r_state;
      w_ld_beat = 1'b0;
      w_ld_tail = 1'b0;
      w_to_idle = 1'b0;
      case (r_state)
         IDLE: if (w_launch) begin
            w_nstate  = DATA;
            w_ld_beat = 1'b1;
         end
         DATA: if (w_acc) begin
            if (r_left == LW'(1)) begin
               w_nstate  = TAIL;
               w_ld_tail = 1'b1;
            end else begin
               w_ld_beat = 1'b1;
            end
         end
         TAIL: if (w_acc) begin
            w_nstate  = IDLE;
            w_to_idle = 1'b1;
         end
         default: w_nstate = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_pv   <= '0;
         r_pa   <= '0;
         r_pd   <= '0;
         r_sent <= '0;
         r_idx  <= '0;
         r_left <= '0;
         r_fp   <= 1'b0;
      end else begin
         if (w_rel) begin
            r_sent <= r_sent + 64'd1;
            r_idx  <= r_idx + RL'(1);
            r_left <= r_left - LW'(1);
         end
         if (w_launch) r_left <= w_len;
         if (w_ld_beat) begin
            r_pv <= 2'b11;
            r_pa <= ADDR_VAL + 64'(w_idx_ld) * BB;
            r_pd <= w_head;
         end else if (w_ld_tail) begin
            // Tail carries the count including the beat accepted this cycle.
            r_pv <= 2'b01;
            r_pa <= TAIL_ADDR;
            r_pd <= {{W2{1'b0}}, W2'(r_sent + 64'd1)};
         end else if (w_to_idle) begin
            r_pv <= '0;
         end
         if (flush)                              r_fp <= 1'b1;
         else if (r_state == IDLE && w_cnt == '0) r_fp <= 1'b0;
      end
   end

   assign bus.pcie_v = r_pv;
   assign bus.pcie_a = r_pa;
   assign bus.pcie_d = r_pd;
   assign sent       = r_sent;
   assign busy       = (r_state != IDLE) || (w_cnt != '0);
endmodule

// File: doc/pcie_inorder_tx.md
Name: pcie_inorder_tx

Overview:
- Card-to-host counterpart of the host-to-card in-order receiver.
- Accepts an in-order stream of W-bit words and buffers them in a D-entry FIFO.
- Emits them as PCIe write beats into a host ring buffer: two W/2 halves per beat, address advancing by W/8 bytes per beat.
- After each burst, writes a 64-bit tail (total beats sent) to a host doorbell address. Host consumption is flow-controlled by a credit input.

Parameters:
- ADDR_VAL, 64'h0000_0000_0000_0000: host ring base byte address.
- TAIL_ADDR, 64'h0000_0000_0001_0000: host byte address of the tail-count write.
- W, 512: beat width in bits.
- D, 512: FIFO depth in words; power of 2.
- BURST, 8: maximum beats per burst; 1..D.
- RING, 4096: host ring size in beats; power of 2, ≥BURST.
- W2, W/2: half-beat width.
- D_L, $clog2(D): FIFO address width.

Ports:
- clk, in, 1: clock.
- rst, in, 1: reset, synchronous, active-high.
- in_v, in, 1: input word valid.
- in_d, in, W: input word.
- in_r, out, 1: input ready; a word is accepted when in_v & in_r.
- flush, in, 1: pulse; forces a partial burst of whatever is buffered.
- host_head, in, 64: beats consumed by host (monotonic).
- pcie_v, out, 2: per-half write valid.
- pcie_a, out, 64: write byte address.
- pcie_d, out, 2×W2: write data; [0] is the low half.
- pcie_r, in, 1: shell accepts the current beat when |pcie_v & pcie_r.
- sent, out, 64: total data beats accepted by the shell.
- busy, out, 1: state != IDLE or FIFO non-empty.

Behaviour:
- Reset:
  - pcie_v=0, pcie_a=0, pcie_d=0, sent=0, busy=0, in_r=0.
  - FIFO empty, wr_idx=0, state IDLE, flush_pending=0.
  - in_r rises the cycle after rst falls. rst mid-burst discards the FIFO and the in-flight burst.
- FIFO:
  - in_r = (count < D). Accepting a word increments count.
  - Simultaneous accept and read leaves count unchanged.
  - Storage read latency is 1 cycle.
  - Data order is strictly preserved.
- flush:
  - Sets flush_pending.
  - flush_pending clears when IDLE is entered with count==0.
  - flush with an empty FIFO and no burst in flight is a no-op.
- Credit: free = RING − (sent − host_head), 64-bit modular arithmetic.
- State IDLE:
  - Launch when (count ≥ BURST, or flush_pending & count>0) and free ≥ len, where len = min(count, BURST).
  - On launch, latch len and go to DATA.
  - If free < len, wait in IDLE and re-evaluate every cycle.
- State DATA:
  - pcie_v=2'b11, pcie_a = ADDR_VAL + wr_idx·(W/8), pcie_d = FIFO head word.
  - Output registers hold stable while pcie_r=0.
  - Each accepted beat: wr_idx = (wr_idx+1) mod RING, sent += 1, FIFO pops.
  - After the len-th accepted beat go to TAIL.
  - No bubbles between beats while pcie_r=1.
- State TAIL:
  - pcie_v=2'b01, pcie_a=TAIL_ADDR, pcie_d[0] = zero-extended sent (already including the burst), pcie_d[1]=0.
  - Held until accepted, then go to IDLE; pcie_v=0 the next cycle unless a new launch occurs.
- Latency: with pcie_r=1 and credit available, the first beat is valid ≤4 cycles after the launch condition becomes true.
- Wrap: wr_idx wraps from RING−1 to 0 mid-burst with no gap; the address returns to ADDR_VAL.
- Input words arriving during a burst are buffered and never join the current burst; len is fixed at launch.
- pcie_v is never asserted outside DATA/TAIL.
- pcie_a is always a multiple of W/8 during DATA.

Decomposition:
- Package pcie_tx_pkg:
  - state enum {IDLE, DATA, TAIL};
  - BEAT_BYTES = W/8 localparam function;
  - 64-bit count typedef.
- Sub-module pcie_tx_fifo:
  - D×W FIFO built on simple_dual_port_ram ("read_first", common_clock);
  - first-word-fall-through output register, count, in_r.
- The top holds the FSM, credit arithmetic, address generation and the output register.

Test Plan:
- Burst: rst, then 8 words 0..7 with pcie_r=1 → exactly 8 beats at 0x0,0x40,…,0x1C0 carrying data 0..7, then 1 tail beat at TAIL_ADDR with pcie_d[0]=8; sent=8, busy=0 after.
- Flush: 3 words, then flush pulse → 3 beats then tail=3. A second flush with an empty FIFO → no pcie_v.
- Backpressure: random pcie_r at 30% duty, 64 words → beats in order with no drop or duplicate; pcie_a/pcie_d stable whenever pcie_v & !pcie_r; final tail=64.
- Wrap: RING=16, host_head tracking sent, 24 words → beat 16 written at address 0x0; tails 8,16,24.
- Credit: RING=16, host_head=0, 24 words → only 16 beats sent, then stall. Set host_head=8 → remaining 8 beats follow, tail=24.
- Full/reset: pcie_r=0, 520 words offered → in_r=0 once D words are buffered. rst mid-DATA → pcie_v=0, sent=0, in_r=1 the cycle after rst falls.
